// File: rtl/wvb_readout_arbiter.sv
// Waveform buffer readout arbiter.
// Picks a channel with a pending header in round-robin order, pops the header,
// streams the waveform samples through a 2-entry skid FIFO with sop/eop
// framing, then pulses end-of-waveform back to the served channel.
`timescale 1ns/1ps
module wvb_readout_arbiter #(
    parameter int P_N_CHAN     = 4,
    parameter int P_DATA_WIDTH = 28,
    parameter int P_HDR_WIDTH  = 87,
    parameter int P_ADR_WIDTH  = 15,
    parameter int P_START_LSB  = 0,
    parameter int P_STOP_LSB   = 15
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [P_N_CHAN-1:0]               ch_mask,
    input  logic [P_N_CHAN-1:0]               hdr_empty,
    input  logic [P_N_CHAN*P_HDR_WIDTH-1:0]   hdr_data,
    input  logic [P_N_CHAN*P_DATA_WIDTH-1:0]  wvb_data,
    output logic [P_N_CHAN-1:0]               hdr_rdreq,
    output logic [P_N_CHAN-1:0]               wvb_rdreq,
    output logic [P_N_CHAN-1:0]               wvb_rddone,
    output logic [P_DATA_WIDTH-1:0]           dout,
    output logic                              dout_valid,
    input  logic                              dout_ready,
    output logic                              dout_sop,
    output logic                              dout_eop,
    output logic [$clog2(P_N_CHAN)-1:0]       dout_chan,
    output logic [P_HDR_WIDTH-1:0]            hdr_out,
    output logic                              busy
);

    localparam int CW = $clog2(P_N_CHAN);
    // remaining needs one extra bit so a full-buffer wrap (2^P_ADR_WIDTH words) fits
    localparam int RW = P_ADR_WIDTH + 1;
    // skid entry = {sop, eop, data}
    localparam int SW = P_DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POP    = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic [P_N_CHAN-1:0] onehot(input logic [CW-1:0] c);
        logic [P_N_CHAN-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // per-channel views of the packed input buses
    logic [P_HDR_WIDTH-1:0]  hdr_word [P_N_CHAN];
    logic [P_DATA_WIDTH-1:0] wvb_word [P_N_CHAN];

    genvar gi;
    generate
        for (gi = 0; gi < P_N_CHAN; gi++) begin : g_unpack
            assign hdr_word[gi] = hdr_data[gi*P_HDR_WIDTH +: P_HDR_WIDTH];
            assign wvb_word[gi] = wvb_data[gi*P_DATA_WIDTH +: P_DATA_WIDTH];
        end
    endgenerate

    // arbiter / sequencing state
    state_t                  state_reg;
    logic [CW-1:0]           chan_reg;
    logic [CW-1:0]           last_reg;
    logic [P_HDR_WIDTH-1:0]  hdr_out_reg;
    logic [RW-1:0]           remaining_reg;
    logic                    first_req_reg;
    logic [P_N_CHAN-1:0]     hdr_rdreq_reg;
    logic [P_N_CHAN-1:0]     wvb_rddone_reg;

    // skid FIFO and read pipeline
    logic [SW-1:0]           skid_mem [2];
    logic [1:0]              skid_cnt_reg;
    logic                    skid_wr_ptr_reg;
    logic                    skid_rd_ptr_reg;
    logic                    inflight_reg;
    logic                    inflight_sop_reg;
    logic                    inflight_eop_reg;

    // round-robin pick
    int                      rr_idx;
    logic [CW-1:0]           rr_sel;
    logic                    pick_found;
    logic [CW-1:0]           pick_chan;
    logic [P_HDR_WIDTH-1:0]  pick_hdr;
    logic [P_ADR_WIDTH-1:0]  pick_start;
    logic [P_ADR_WIDTH-1:0]  pick_stop;
    logic [P_ADR_WIDTH-1:0]  pick_len;
    logic [RW-1:0]           pick_remaining;

    logic [SW-1:0]           skid_head;
    logic                    skid_pop;
    logic                    eop_accept;
    logic                    rd_issue;

    // first eligible channel after the last one served, wrapping around
    always_comb begin
        pick_found = 1'b0;
        pick_chan  = '0;
        rr_idx     = 0;
        rr_sel     = '0;
        for (int i = 1; i <= P_N_CHAN; i++) begin
            rr_idx = int'(last_reg) + i;
            if (rr_idx >= P_N_CHAN) begin
                rr_idx = rr_idx - P_N_CHAN;
            end
            rr_sel = CW'(rr_idx);
            if (!pick_found && ch_mask[rr_sel] && !hdr_empty[rr_sel]) begin
                pick_found = 1'b1;
                pick_chan  = rr_sel;
            end
        end
    end

    // waveform length from the picked header; a zero length means a full wrap
    assign pick_hdr       = hdr_word[pick_chan];
    assign pick_start     = pick_hdr[P_START_LSB +: P_ADR_WIDTH];
    assign pick_stop      = pick_hdr[P_STOP_LSB +: P_ADR_WIDTH];
    assign pick_len       = pick_stop - pick_start + P_ADR_WIDTH'(1);
    assign pick_remaining = (pick_len == '0) ? {1'b1, {P_ADR_WIDTH{1'b0}}} : {1'b0, pick_len};

    // skid head and output handshake; outputs read as zero while empty
    assign skid_head  = skid_mem[skid_rd_ptr_reg];
    assign dout_valid = (skid_cnt_reg != 2'd0);
    assign dout       = dout_valid ? skid_head[P_DATA_WIDTH-1:0] : '0;
    assign dout_sop   = dout_valid & skid_head[SW-1];
    assign dout_eop   = dout_valid & skid_head[SW-2];
    assign skid_pop   = dout_valid & dout_ready;
    assign eop_accept = skid_pop & skid_head[SW-2];

    // never let buffered + in-flight samples exceed the two skid slots
    assign rd_issue  = (state_reg == S_STREAM) && (remaining_reg != '0) &&
                       (({1'b0, skid_cnt_reg} + {2'b00, inflight_reg}) < 3'd2);
    assign wvb_rdreq = rd_issue ? onehot(chan_reg) : '0;

    // main sequencer: pick, pop header, stream, signal completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            chan_reg       <= '0;
            last_reg       <= CW'(P_N_CHAN - 1);
            hdr_out_reg    <= '0;
            remaining_reg  <= '0;
            first_req_reg  <= 1'b0;
            hdr_rdreq_reg  <= '0;
            wvb_rddone_reg <= '0;
        end else begin
            hdr_rdreq_reg  <= '0;
            wvb_rddone_reg <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (en && pick_found) begin
                        chan_reg      <= pick_chan;
                        hdr_out_reg   <= pick_hdr;
                        remaining_reg <= pick_remaining;
                        first_req_reg <= 1'b1;
                        hdr_rdreq_reg <= onehot(pick_chan);
                        state_reg     <= S_POP;
                    end
                end
                S_POP: begin
                    state_reg <= S_STREAM;
                end
                S_STREAM: begin
                    if (rd_issue) begin
                        remaining_reg <= remaining_reg - RW'(1);
                        first_req_reg <= 1'b0;
                    end
                    if (eop_accept) begin
                        wvb_rddone_reg <= onehot(chan_reg);
                        state_reg      <= S_DONE;
                    end
                end
                S_DONE: begin
                    last_reg  <= chan_reg;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // read pipeline tracking and skid occupancy/pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_reg     <= 1'b0;
            inflight_sop_reg <= 1'b0;
            inflight_eop_reg <= 1'b0;
            skid_cnt_reg     <= 2'd0;
            skid_wr_ptr_reg  <= 1'b0;
            skid_rd_ptr_reg  <= 1'b0;
        end else begin
            inflight_reg     <= rd_issue;
            inflight_sop_reg <= rd_issue & first_req_reg;
            inflight_eop_reg <= rd_issue & (remaining_reg == RW'(1));
            if (inflight_reg) begin
                skid_wr_ptr_reg <= ~skid_wr_ptr_reg;
            end
            if (skid_pop) begin
                skid_rd_ptr_reg <= ~skid_rd_ptr_reg;
            end
            case ({inflight_reg, skid_pop})
                2'b10:   skid_cnt_reg <= skid_cnt_reg + 2'd1;
                2'b01:   skid_cnt_reg <= skid_cnt_reg - 2'd1;
                default: skid_cnt_reg <= skid_cnt_reg;
            endcase
        end
    end

    // skid storage: capture the sample returned one cycle after its request
    always_ff @(posedge clk) begin
        if (inflight_reg) begin
            skid_mem[skid_wr_ptr_reg] <= {inflight_sop_reg, inflight_eop_reg, wvb_word[chan_reg]};
        end
    end

    assign hdr_rdreq  = hdr_rdreq_reg;
    assign wvb_rddone = wvb_rddone_reg;
    assign dout_chan  = chan_reg;
    assign hdr_out    = hdr_out_reg;
    assign busy       = (state_reg != S_IDLE);

endmodule

// File: doc/wvb_readout_arbiter.md
WVB_READOUT_ARBITER -- requirements
Module: wvb_readout_arbiter

Interface
REQ-001 SHALL take parameter P_N_CHAN, default 4: number of waveform buffer channels served, range 2..16.
REQ-002 SHALL take parameter P_DATA_WIDTH, default 28: width of one waveform sample word.
REQ-003 SHALL take parameter P_HDR_WIDTH, default 87: width of one header word.
REQ-004 SHALL take parameter P_ADR_WIDTH, default 15: waveform buffer address width.
REQ-005 SHALL take parameter P_START_LSB, default 0: LSB of the start address field in a header; the field is P_ADR_WIDTH bits wide.
REQ-006 SHALL take parameter P_STOP_LSB, default 15: LSB of the stop address field in a header; the field is P_ADR_WIDTH bits wide.
REQ-007 SHALL have these ports, in this order:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  arbitration enable.
- ch_mask  in  P_N_CHAN  1 = channel eligible for service.
- hdr_empty  in  P_N_CHAN  per-channel header FIFO empty flag.
- hdr_data  in  P_N_CHAN*P_HDR_WIDTH  per-channel header FIFO head word; channel k occupies bits [k*P_HDR_WIDTH +: P_HDR_WIDTH].
- wvb_data  in  P_N_CHAN*P_DATA_WIDTH  per-channel sample read data, packed by channel the same way.
- hdr_rdreq  out  P_N_CHAN  one-cycle header pop, one-hot.
- wvb_rdreq  out  P_N_CHAN  sample read request, one-hot.
- wvb_rddone  out  P_N_CHAN  one-cycle end-of-waveform pulse, one-hot.
- dout  out  P_DATA_WIDTH  output sample.
- dout_valid  out  1  dout qualifier.
- dout_ready  in  1  downstream accept.
- dout_sop  out  1  marks the first sample of a waveform.
- dout_eop  out  1  marks the last sample of a waveform.
- dout_chan  out  clog2(P_N_CHAN)  source channel of the current sample.
- hdr_out  out  P_HDR_WIDTH  header of the waveform in progress.
- busy  out  1  high in every state except IDLE.

Function
REQ-008 SHALL treat the header FIFOs as first-word-fall-through: hdr_data of channel k is valid whenever hdr_empty[k] is 0.
REQ-009 SHALL treat sample storage as fixed 1-cycle read latency: wvb_data of channel k is valid on the cycle after wvb_rdreq[k].
REQ-010 SHALL implement the FSM states IDLE, POP, STREAM and DONE.
REQ-011 SHALL, in IDLE with en=1, select the first channel k in round-robin order, starting at last-served+1 and wrapping, for which ch_mask[k]=1 and hdr_empty[k]=0; if no channel qualifies it SHALL stay in IDLE.
REQ-012 SHALL, in POP (one cycle), assert hdr_rdreq[k], register the header into hdr_out and dout_chan, and load remaining = (stop - start + 1) mod 2^P_ADR_WIDTH; the result 0 SHALL mean 2^P_ADR_WIDTH words (full buffer wrap).
REQ-013 SHALL, in STREAM, assert wvb_rdreq[k] only when (skid occupancy + reads in flight) < 2 and remaining > 0, and SHALL decrement remaining once per request.
REQ-014 SHALL pass returned samples through a 2-entry skid FIFO, with dout_valid = FIFO not empty and a pop when dout_valid && dout_ready; no sample SHALL be dropped or duplicated under any dout_ready pattern.
REQ-015 SHALL assert dout_sop on the first sample of each waveform and dout_eop on the last; both SHALL be 1 together for a 1-word waveform.
REQ-016 SHALL move from STREAM to DONE on the cycle the eop sample is accepted.
REQ-017 SHALL, in DONE (one cycle), pulse wvb_rddone[k], update last-served to k, and return to IDLE.
REQ-018 SHALL keep the minimum gap from DONE to the next POP at 1 cycle (IDLE).
REQ-019 SHALL ignore deassertion of en or ch_mask[k] during POP, STREAM or DONE: the current waveform SHALL always complete.
REQ-020 SHALL keep hdr_out and dout_chan stable from POP until the next POP.

Reset
REQ-021 SHALL, on rst=1 at any cycle, including mid-STREAM, enter IDLE on the next edge and clear the skid FIFO, in-flight count and remaining.
REQ-022 SHALL, after reset, set last-served to P_N_CHAN-1, so that channel 0 has first priority.
REQ-023 SHALL drive all outputs to 0 during reset: hdr_rdreq, wvb_rdreq, wvb_rddone, dout, dout_valid, dout_sop, dout_eop, dout_chan, hdr_out and busy.
REQ-024 SHALL NOT generate a wvb_rddone pulse for a waveform aborted by reset.

Verification
REQ-025 SHALL cover: ch0 header start=10, stop=13, dout_ready=1 -> 4 samples, sop on sample 1, eop on sample 4, dout_chan=0, wvb_rddone[0] 1 cycle after eop accept.
REQ-026 SHALL cover: ch1 and ch3 non-empty together after reset, then ch1 refilled -> service order ch1, ch3, ch1.
REQ-027 SHALL cover: start=32760, stop=5 (wrap) -> exactly 14 samples.
REQ-028 SHALL cover: dout_ready random at 30% duty over a 100-word waveform -> all 100 words delivered in order, and at most 2 reads outstanding plus buffered at any time.
REQ-029 SHALL cover: ch_mask=4'b1101 with ch1 non-empty -> ch1 never served; when en=0, no hdr_rdreq is issued.
REQ-030 SHALL cover: rst asserted at sample 3 of 8 -> all outputs 0 on the next cycle, no wvb_rddone, and the next header after reset is served from channel 0 first.
